// File: rtl/ddfs_env_gen.sv
// ddfs_env_gen
// ADSR envelope generator feeding the DDFS amplitude-modulation input.
// A 32-bit accumulator ramps through attack / decay / sustain / release,
// advancing one step per tick strobe; env is the upper half of it and
// stays within 0..0x7FFF.
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   asynchronous, active-high
//   start          in   gate-on / retrigger pulse (wins over stop)
//   stop           in   gate-off pulse (ignored in IDLE / RELEASE)
//   tick           in   step enable
//   attack_step    in   32-bit increment per tick in ATTACK
//   decay_step     in   32-bit decrement per tick in DECAY
//   sustain_level  in   16-bit sustain target, clamped to 0x7FFF
//   release_step   in   32-bit decrement per tick in RELEASE
//   env            out  envelope value, acc[31:16]
//   env_idle       out  high while IDLE
//   env_done       out  one-cycle pulse on RELEASE -> IDLE
//
// state   | meaning
// IDLE    | envelope off, acc held at 0
// ATTACK  | ramping up toward MAX
// DECAY   | ramping down toward the sustain level
// SUSTAIN | acc tracks the (live) sustain level
// RELEASE | ramping down toward 0

module ddfs_env_gen (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        stop,
   input  logic        tick,
   input  logic [31:0] attack_step,
   input  logic [31:0] decay_step,
   input  logic [15:0] sustain_level,
   input  logic [31:0] release_step,
   output logic [15:0] env,
   output logic        env_idle,
   output logic        env_done
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ATTACK  = 3'd1,
      DECAY   = 3'd2,
      SUSTAIN = 3'd3,
      RELEASE = 3'd4
   } state_t;

   localparam logic [31:0] MAX = 32'h7FFF_FFFF;

   state_t      r_state;
   state_t      w_nxt_state;
   logic [31:0] r_acc;
   logic [31:0] w_nxt_acc;
   logic        r_done;
   logic        w_nxt_done;
   logic [31:0] w_s;
   logic        w_gated;

   assign w_s = {(sustain_level[15] ? 16'h7FFF : sustain_level), 16'h0000};

   assign w_gated = (r_state == ATTACK) || (r_state == DECAY) || (r_state == SUSTAIN);

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_acc   = r_acc;
      w_nxt_done  = 1'b0;
      if (start) begin
         w_nxt_state = ATTACK;
      end else if (stop && w_gated) begin
         w_nxt_state = RELEASE;
      end else if (tick) begin
         case (r_state)
            ATTACK: begin
               if ((attack_step == 32'd0) || ((MAX - r_acc) <= attack_step)) begin
                  w_nxt_acc   = MAX;
                  w_nxt_state = DECAY;
               end else begin
                  w_nxt_acc = r_acc + attack_step;
               end
            end
            DECAY: begin
               // The acc <= S guard covers a sustain level raised above acc
               // mid-decay, which would otherwise make the difference wrap.
               if ((decay_step == 32'd0) || (r_acc <= w_s) ||
                   ((r_acc - w_s) <= decay_step)) begin
                  w_nxt_acc   = w_s;
                  w_nxt_state = SUSTAIN;
               end else begin
                  w_nxt_acc = r_acc - decay_step;
               end
            end
            SUSTAIN: begin
               w_nxt_acc = w_s;
            end
            RELEASE: begin
               if ((release_step == 32'd0) || (r_acc <= release_step)) begin
                  w_nxt_acc   = 32'd0;
                  w_nxt_state = IDLE;
                  w_nxt_done  = 1'b1;
               end else begin
                  w_nxt_acc = r_acc - release_step;
               end
            end
            IDLE: begin
               w_nxt_acc = 32'd0;
            end
            default: begin
               w_nxt_acc   = 32'd0;
               w_nxt_state = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_acc   <= 32'd0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         r_acc   <= w_nxt_acc;
         r_done  <= w_nxt_done;
      end
   end

   assign env      = r_acc[31:16];
   assign env_idle = (r_state == IDLE);
   assign env_done = r_done;

endmodule

// File: tb/tb_ddfs_env_gen.sv
module tb_ddfs_env_gen;

   logic        clk;
   logic        reset;
   logic        start;
   logic        stop;
   logic        tick;
   logic [31:0] attack_step;
   logic [31:0] decay_step;
   logic [15:0] sustain_level;
   logic [31:0] release_step;
   logic [15:0] env;
   logic        env_idle;
   logic        env_done;

   int n_checks;
   int n_fail;

   ddfs_env_gen dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .stop          (stop),
      .tick          (tick),
      .attack_step   (attack_step),
      .decay_step    (decay_step),
      .sustain_level (sustain_level),
      .release_step  (release_step),
      .env           (env),
      .env_idle      (env_idle),
      .env_done      (env_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // advance one clock; leaves time 1 ns after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      reset         = 1'b1;
      start         = 1'b0;
      stop          = 1'b0;
      tick          = 1'b1;
      attack_step   = 32'h0800_0000;
      decay_step    = 32'h1000_0000;
      sustain_level = 16'h4000;
      release_step  = 32'h2000_0000;
      #2;
      chk("rst_env",  env, 32'h0);
      chk("rst_idle", env_idle, 32'h1);
      chk("rst_done", env_done, 32'h0);
      step();
      step();
      reset = 1'b0;
      step();

      // reset asserted mid-attack acts without a clock edge
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      step();
      chk("pre_rst_env", env, 32'h1800);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_env",  env, 32'h0);
      chk("async_rst_idle", env_idle, 32'h1);
      step();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) step();
      chk("post_rst_env",  env, 32'h0);
      chk("post_rst_idle", env_idle, 32'h1);

      // attack: start cycle does not step
      start = 1'b1;
      step();
      start = 1'b0;
      chk("start_env",  env, 32'h0);
      chk("start_idle", env_idle, 32'h0);
      for (int k = 1; k <= 15; k++) begin
         step();
         chk("attack_env", env, 32'(k) * 32'h0800);
      end
      step();
      chk("attack_top", env, 32'h7FFF);

      // decay with a 50-cycle tick gap in the middle
      step();
      chk("decay1", env, 32'h6FFF);
      step();
      chk("decay2", env, 32'h5FFF);
      tick = 1'b0;
      for (int i = 0; i < 50; i++) step();
      chk("gated_env",  env, 32'h5FFF);
      chk("gated_idle", env_idle, 32'h0);
      tick = 1'b1;
      step();
      chk("decay3", env, 32'h4FFF);
      step();
      chk("decay4_sus", env, 32'h4000);
      begin
         int bad;
         bad = 0;
         for (int i = 0; i < 20; i++) begin
            step();
            if (env !== 16'h4000) bad++;
         end
         chk("sustain_hold_errs", 32'(bad), 32'h0);
      end

      // release
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("stop_env", env, 32'h4000);
      step();
      chk("rel1_env",  env, 32'h2000);
      chk("rel1_done", env_done, 32'h0);
      chk("rel1_idle", env_idle, 32'h0);
      step();
      chk("rel2_env",  env, 32'h0);
      chk("rel2_done", env_done, 32'h1);
      chk("rel2_idle", env_idle, 32'h1);
      step();
      chk("rel3_done", env_done, 32'h0);

      // stop in IDLE is ignored
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("idle_stop", env_idle, 32'h1);

      // back to sustain, then simultaneous start+stop
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 20; i++) step();
      chk("sus2_env", env, 32'h4000);
      start = 1'b1;
      stop  = 1'b1;
      step();
      start = 1'b0;
      stop  = 1'b0;
      chk("retrig_env",  env, 32'h4000);
      chk("retrig_idle", env_idle, 32'h0);
      step();
      chk("retrig_step", env, 32'h4800);

      // zero attack step jumps to the top
      attack_step = 32'h0;
      step();
      chk("zero_attack", env, 32'h7FFF);

      // clamped sustain level
      sustain_level = 16'hFFFF;
      step();
      chk("clamp_sus1", env, 32'h7FFF);
      step();
      chk("clamp_sus2", env, 32'h7FFF);
      sustain_level = 16'h2000;
      step();
      chk("sus_track", env, 32'h2000);

      // zero release step ends at once
      release_step = 32'h0;
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("zrel_stop_env", env, 32'h2000);
      step();
      chk("zrel_env",  env, 32'h0);
      chk("zrel_done", env_done, 32'h1);
      chk("zrel_idle", env_idle, 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
